// File: rtl/io_lut_slave.sv
// Programmable lookup-table slave on the io bus: control/status/scratch registers plus a dual-port LUT.
// Optional access counters (reg2/reg3) are built only when IO_LUT_COUNTERS_EN is defined.
module io_lut_slave #(
    parameter logic [3:0] MODULE_ID  = 4'h1,
    parameter int         N_REGS     = 8,
    parameter int         LUT_AW     = 8,
    parameter int         RD_LATENCY = 2
) (
    input  logic              io_clk,
    input  logic              reset_n,
    input  logic              io_sel,
    input  logic              io_sync,
    input  logic [27:0]       io_addr,
    input  logic              io_rd_en,
    input  logic              io_wr_en,
    input  logic [31:0]       io_wr_data,
    output logic [31:0]       io_rd_data,
    output logic              io_rd_ack,
    output logic [31:0]       ctrl_out,
    input  logic [LUT_AW-1:0] user_addr,
    output logic [31:0]       user_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               space_q;
    logic [LUT_AW-1:0]  lut_idx_q;
    logic [3:0]         reg_idx_q;
    logic [31:0]        reg_rd_q;
    logic [31:0]        lut_rd_q;
    logic [31:0]        user_rd_q;
    logic [31:0]        regs_q [16];
    logic [31:0]        lut_mem [2**LUT_AW];
    logic [31:0]        wr_cnt, rd_cnt;
    logic [31:0]        reg_rd_val;

    logic               hit, rd_start, wr_hit, wr_lut, wr_reg, reg_writable;
    logic               ack_enter, lut_rd_en;
    logic [3:0]         rd_reg_idx;
    logic [LUT_AW-1:0]  rd_lut_idx;
    logic               unused_addr;

    assign hit          = io_sel && (io_addr[27:24] == MODULE_ID);
    assign rd_start     = io_sync && io_rd_en && hit;
    assign wr_hit       = io_wr_en && hit;
    assign wr_lut       = wr_hit && io_addr[23];
    assign wr_reg       = wr_hit && !io_addr[23];
    assign reg_writable = (int'(io_addr[3:0]) < N_REGS) &&
                          ((io_addr[3:0] == 4'd0) || (io_addr[3:0] >= 4'd4));
    assign unused_addr  = ^{io_addr[22:LUT_AW]};

    // While idle the read path looks straight at the bus so a 1-cycle latency is possible.
    assign rd_reg_idx = (state_q == S_IDLE) ? io_addr[3:0]        : reg_idx_q;
    assign rd_lut_idx = (state_q == S_IDLE) ? io_addr[LUT_AW-1:0] : lut_idx_q;
    assign lut_rd_en  = (state_q != S_ACK);
    assign ack_enter  = (state_d == S_ACK) && (state_q != S_ACK);

    // The counter starts at 1: the accepting cycle is the first latency cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    cnt_d   = 3'd1;
                    state_d = (RD_LATENCY == 1) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!io_sync)                           state_d = S_IDLE;
                else if (cnt_q == 3'(RD_LATENCY - 1))   state_d = S_ACK;
                else                                    cnt_d   = cnt_q + 3'd1;
            end
            S_ACK: begin
                if (!io_sync) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            space_q   <= 1'b0;
            lut_idx_q <= '0;
            reg_idx_q <= '0;
            reg_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && rd_start) begin
                space_q   <= io_addr[23];
                lut_idx_q <= io_addr[LUT_AW-1:0];
                reg_idx_q <= io_addr[3:0];
            end
            if (ack_enter) reg_rd_q <= reg_rd_val;
        end
    end

    always_comb begin
        io_rd_ack  = (state_q == S_ACK);
        io_rd_data = '0;
        if (state_q == S_ACK) io_rd_data = space_q ? lut_rd_q : reg_rd_q;
    end

    always_comb begin
        case (rd_reg_idx)
            4'd0:    reg_rd_val = regs_q[0];
            4'd1:    reg_rd_val = {16'h0, 8'(N_REGS), 8'(LUT_AW)};
            4'd2:    reg_rd_val = wr_cnt;
            4'd3:    reg_rd_val = rd_cnt;
            default: reg_rd_val = regs_q[rd_reg_idx];
        endcase
        if (int'(rd_reg_idx) >= N_REGS) reg_rd_val = 32'hDEAD_BEEF;
    end

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (wr_reg && reg_writable) begin
            regs_q[io_addr[3:0]] <= io_wr_data;
        end
    end

    assign ctrl_out = regs_q[0];

`ifdef IO_LUT_COUNTERS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_hit)    wr_cnt_q <= wr_cnt_q + 32'd1;
            if (ack_enter) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`else
    assign wr_cnt = '0;
    assign rd_cnt = '0;
`endif

    // Port A: io write plus read-first registered read, frozen during ACK so the data holds.
    always_ff @(posedge io_clk) begin
        if (wr_lut)    lut_mem[io_addr[LUT_AW-1:0]] <= io_wr_data;
        if (lut_rd_en) lut_rd_q <= lut_mem[rd_lut_idx];
    end

    // Port B: user read; a same-cycle io write to the same word yields the old word.
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) user_rd_q <= '0;
        else          user_rd_q <= lut_mem[user_addr];
    end

    assign user_rd_data = user_rd_q;

endmodule

// File: tb/tb_io_lut_slave.sv
// Randomised scoreboard bench for io_lut_slave: reference model of registers/LUT/counters,
// a monitor that pops expected read responses on each io_rd_ack rise, plus directed corner cases.
module tb_io_lut_slave;

    localparam logic [3:0] MODULE_ID = 4'h1;
    localparam int N_REGS = 8;
    localparam int LUT_AW = 8;
    localparam int RD_LAT = 2;

    logic              io_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              io_sel = 1'b0;
    logic              io_sync = 1'b0;
    logic [27:0]       io_addr = '0;
    logic              io_rd_en = 1'b0;
    logic              io_wr_en = 1'b0;
    logic [31:0]       io_wr_data = '0;
    logic [31:0]       io_rd_data;
    logic              io_rd_ack;
    logic [31:0]       ctrl_out;
    logic [LUT_AW-1:0] user_addr = '0;
    logic [31:0]       user_rd_data;

    io_lut_slave #(
        .MODULE_ID (MODULE_ID),
        .N_REGS    (N_REGS),
        .LUT_AW    (LUT_AW),
        .RD_LATENCY(RD_LAT)
    ) dut (
        .io_clk      (io_clk),
        .reset_n     (reset_n),
        .io_sel      (io_sel),
        .io_sync     (io_sync),
        .io_addr     (io_addr),
        .io_rd_en    (io_rd_en),
        .io_wr_en    (io_wr_en),
        .io_wr_data  (io_wr_data),
        .io_rd_data  (io_rd_data),
        .io_rd_ack   (io_rd_ack),
        .ctrl_out    (ctrl_out),
        .user_addr   (user_addr),
        .user_rd_data(user_rd_data)
    );

    always #5 io_clk = ~io_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge io_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          start;
    } exp_t;
    exp_t exp_q[$];

    // Reference model
    logic [31:0] m_reg [16];
    logic [31:0] m_lut [2**LUT_AW];
    bit          m_lut_valid [2**LUT_AW];
    logic [31:0] m_wr_cnt, m_rd_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] reg_addr(input logic [3:0] idx);
        return {MODULE_ID, 1'b0, 19'd0, idx};
    endfunction

    function automatic logic [27:0] lut_addr(input logic [LUT_AW-1:0] idx);
        return {MODULE_ID, 1'b1, 15'd0, idx};
    endfunction

    function automatic logic [31:0] model_read(input logic [27:0] a);
        logic [3:0] idx;
        if (a[23]) return m_lut[a[LUT_AW-1:0]];
        idx = a[3:0];
        if (int'(idx) >= N_REGS) return 32'hDEAD_BEEF;
        case (idx)
            4'd1: return {16'h0, 8'(N_REGS), 8'(LUT_AW)};
`ifdef IO_LUT_COUNTERS_EN
            4'd2: return m_wr_cnt;
            4'd3: return m_rd_cnt;
`else
            4'd2: return 32'd0;
            4'd3: return 32'd0;
`endif
            default: return m_reg[idx];
        endcase
    endfunction

    task automatic model_write(input logic [27:0] a, input logic [31:0] d);
        m_wr_cnt++;
        if (a[23]) begin
            m_lut[a[LUT_AW-1:0]]       = d;
            m_lut_valid[a[LUT_AW-1:0]] = 1'b1;
        end else if (int'(a[3:0]) < N_REGS && (a[3:0] == 4'd0 || a[3:0] >= 4'd4)) begin
            m_reg[a[3:0]] = d;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_wr_cnt = '0;
        m_rd_cnt = '0;
    endtask

    // Monitor: pops one expectation per ack rise; checks data, latency and stability.
    logic        ack_prev = 1'b0;
    logic [31:0] cur_data = '0;
    always @(negedge io_clk) begin
        if (io_rd_ack && !ack_prev) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ack", 32'(io_rd_ack), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", io_rd_data, e.data);
                chk("ack_latency", 32'(cyc - e.start), 32'(RD_LAT));
                cur_data = e.data;
            end
        end else if (io_rd_ack) begin
            chk("rd_data_stable", io_rd_data, cur_data);
        end
        ack_prev = io_rd_ack;
    end

    task automatic bus_idle();
        io_sel   = 1'b0;
        io_sync  = 1'b0;
        io_rd_en = 1'b0;
        io_wr_en = 1'b0;
        io_addr  = '0;
    endtask

    task automatic do_write(input logic [27:0] a, input logic [31:0] d);
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_wr_en = 1'b1; io_addr = a; io_wr_data = d;
        model_write(a, d);
        $display("write addr=%h data=%h", a, d);
        @(posedge io_clk); #1;
        bus_idle();
    endtask

    task automatic read_start(input logic [27:0] a, input logic [31:0] exp);
        exp_t e;
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = a;
        e.data  = exp;
        e.start = cyc;
        exp_q.push_back(e);
        m_rd_cnt++;
        $display("read  addr=%h expect=%h", a, exp);
    endtask

    task automatic read_finish();
        int t = 0;
        while (!io_rd_ack && t < 20) begin
            @(negedge io_clk);
            t++;
        end
        if (!io_rd_ack) begin
            chk("ack_timeout", 32'(io_rd_ack), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(posedge io_clk); #1;
        bus_idle();
        @(negedge io_clk);
        @(negedge io_clk);
        chk("ack_drop", 32'(io_rd_ack), 32'd0);
        chk("data_clear", io_rd_data, 32'd0);
    endtask

    task automatic do_read(input logic [27:0] a);
        read_start(a, model_read(a));
        read_finish();
    endtask

    task automatic do_reset();
        @(posedge io_clk); #2;
        reset_n = 1'b0;
        bus_idle();
        model_reset();
        #1;
        chk("rst_ack", 32'(io_rd_ack), 32'd0);
        chk("rst_data", io_rd_data, 32'd0);
        chk("rst_ctrl", ctrl_out, 32'd0);
        chk("rst_user", user_rd_data, 32'd0);
        repeat (2) @(posedge io_clk);
        #3 reset_n = 1'b1;
    endtask

    task automatic user_check(input logic [LUT_AW-1:0] a);
        @(posedge io_clk); #1;
        user_addr = a;
        @(posedge io_clk);
        @(negedge io_clk);
        chk("user_rd", user_rd_data, m_lut[a]);
        $display("user  addr=%h data=%h", a, user_rd_data);
    endtask

    task automatic quiet_check(input string name, input int n);
        repeat (n) @(negedge io_clk);
        chk({name, "_ack"}, 32'(io_rd_ack), 32'd0);
        chk({name, "_data"}, io_rd_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LUT_AW-1:0] la;
        logic [31:0]       old_word;
        logic [27:0]       ra;
        for (int i = 0; i < 2**LUT_AW; i++) begin
            m_lut[i] = '0;
            m_lut_valid[i] = 1'b0;
        end
        model_reset();

        // Power-on reset
        repeat (2) @(posedge io_clk);
        #1;
        chk("por_ack", 32'(io_rd_ack), 32'd0);
        chk("por_data", io_rd_data, 32'd0);
        chk("por_ctrl", ctrl_out, 32'd0);
        chk("por_user", user_rd_data, 32'd0);
        @(negedge io_clk) reset_n = 1'b1;

        // Control register write/read
        do_write(28'h100_0000, 32'h1234_5678);
        chk("ctrl_out", ctrl_out, 32'h1234_5678);
        do_read(28'h100_0000);

        // LUT write then user port and io port readback
        do_write(28'h180_00A5, 32'hCAFE_0001);
        user_check(8'hA5);
        chk("user_lut_a5", user_rd_data, 32'hCAFE_0001);
        do_read(28'h180_00A5);

        // Map corner cases
        do_read(reg_addr(4'd12));
        do_write(reg_addr(4'd1), 32'hFFFF_FFFF);
        do_read(reg_addr(4'd1));
        do_read(reg_addr(4'd7));

        // Non-hit reads: wrong module id, then segment not selected
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = 28'h200_0000;
        quiet_check("nohit_id", 5);
        @(posedge io_clk); #1;
        bus_idle();
        @(posedge io_clk); #1;
        io_sync = 1'b1; io_rd_en = 1'b1; io_addr = 28'h100_0000;
        quiet_check("nohit_sel", 5);
        @(posedge io_clk); #1;
        bus_idle();

        // Abort: io_sync dropped one cycle into the read
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = reg_addr(4'd0);
        @(posedge io_clk); #1;
        bus_idle();
        quiet_check("abort", 5);
        do_read(reg_addr(4'd3));

        // Write performed while a read is in flight
        read_start(reg_addr(4'd0), model_read(reg_addr(4'd0)));
        @(posedge io_clk); #1;
        io_wr_en = 1'b1; io_addr = reg_addr(4'd5); io_wr_data = 32'h5555_AAAA;
        model_write(reg_addr(4'd5), 32'h5555_AAAA);
        @(posedge io_clk); #1;
        io_wr_en = 1'b0; io_addr = reg_addr(4'd0);
        read_finish();
        do_read(reg_addr(4'd5));

        // Same-address io write and user read: user sees the old word
        old_word = m_lut[8'hA5];
        @(posedge io_clk); #1;
        user_addr = 8'hA5;
        io_sel = 1'b1; io_wr_en = 1'b1; io_addr = 28'h180_00A5; io_wr_data = 32'hBEEF_0002;
        model_write(28'h180_00A5, 32'hBEEF_0002);
        @(posedge io_clk); #1;
        bus_idle();
        @(negedge io_clk);
        chk("collide_old", user_rd_data, old_word);
        @(posedge io_clk);
        @(negedge io_clk);
        chk("collide_new", user_rd_data, 32'hBEEF_0002);

        // Reset in the middle of WAIT
        do_write(reg_addr(4'd0), 32'hA5A5_5A5A);
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = reg_addr(4'd0);
        do_reset();
        quiet_check("post_rst", 5);

        // Randomised traffic on RW registers and the LUT
        for (int n = 0; n < 60; n++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                ra = ($urandom_range(0, 1) == 0) ? reg_addr(4'd0)
                     : reg_addr(4'($urandom_range(4, N_REGS - 1)));
                do_write(ra, $urandom);
            end else if (op == 1) begin
                la = LUT_AW'($urandom);
                do_write(lut_addr(la), $urandom);
            end else if (op == 2) begin
                do_read(reg_addr(4'($urandom_range(0, 15))));
            end else begin
                la = LUT_AW'($urandom);
                if (m_lut_valid[la]) do_read(lut_addr(la));
                else                 do_read(reg_addr(4'd1));
            end
        end
        for (int n = 0; n < 8; n++) begin
            la = LUT_AW'($urandom);
            if (m_lut_valid[la]) user_check(la);
        end

        // Counter check from a clean reset: 3 writes, 2 reads
        do_reset();
        do_write(reg_addr(4'd0), 32'h0000_0011);
        do_write(reg_addr(4'd4), 32'h0000_0022);
        do_write(lut_addr(8'h10), 32'h0000_0033);
        do_read(reg_addr(4'd0));
        do_read(reg_addr(4'd4));
`ifdef IO_LUT_COUNTERS_EN
        read_start(reg_addr(4'd3), 32'd2);
        read_finish();
        read_start(reg_addr(4'd2), 32'd3);
        read_finish();
`else
        read_start(reg_addr(4'd3), 32'd0);
        read_finish();
        read_start(reg_addr(4'd2), 32'd0);
        read_finish();
`endif

        repeat (3) @(negedge io_clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
